// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_pkg
//  Description : Shared constants, prefetch entry type and branch predecode
//                helper for the instruction-fetch stage.
//  Revision    : 1.0  initial release
// ============================================================================
package if_pkg;

   localparam int INSTR_W = 32;
   localparam int PC_W    = 32;

   // Branch opcode class of the ARM subset lives in bits 27:25.
   localparam logic [2:0] BRANCH_OPC    = 3'b101;
   localparam int         BRANCH_OPC_HI = 27;
   localparam int         BRANCH_OPC_LO = 25;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
      logic               is_branch;
   } fetch_entry_t;

   function automatic logic is_branch_opc(input logic [INSTR_W-1:0] instr);
      return instr[BRANCH_OPC_HI:BRANCH_OPC_LO] == BRANCH_OPC;
   endfunction

endpackage
`default_nettype wire

// File: rtl/if_prefetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_prefetch_stage_if
//  Description : Control, instruction-memory and ID-side handshake bundle of
//                the fetch stage. master = fetch stage, slave = environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface if_prefetch_stage_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              freeze;
   logic              Branch_taken;
   logic [ADDR_W-1:0] BranchAddr;
   logic              imem_en;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_rdata;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_pc;
   logic [DATA_W-1:0] out_instr;
   logic              out_is_branch;

   modport master (
      input  freeze, Branch_taken, BranchAddr, imem_rdata, out_ready,
      output imem_en, imem_addr, out_valid, out_pc, out_instr, out_is_branch
   );

   modport slave (
      output freeze, Branch_taken, BranchAddr, imem_rdata, out_ready,
      input  imem_en, imem_addr, out_valid, out_pc, out_instr, out_is_branch
   );
endinterface
`default_nettype wire

// File: rtl/if_fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_fifo
//  Description : DEPTH-entry synchronous prefetch FIFO (DEPTH power of two).
//                clear dominates push and pop. Branch flag storage exists
//                only when FLAG_EN is set.
//  Revision    : 1.0  initial release
// ============================================================================
module if_fetch_fifo
   import if_pkg::*;
#(
   parameter  int DEPTH   = 4,
   parameter  bit FLAG_EN = 1'b0,
   localparam int PTR_W   = $clog2(DEPTH),
   localparam int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  fetch_entry_t     push_entry,
   output fetch_entry_t     head_entry,
   output logic [CNT_W-1:0] count
);

   logic [PC_W-1:0]    r_pc_mem    [DEPTH];
   logic [INSTR_W-1:0] r_instr_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic               w_do_push;
   logic               w_do_pop;
   logic               w_head_flag;

   assign w_do_push = push & ~clear;
   assign w_do_pop  = pop & ~clear & (r_count != '0);
   assign count     = r_count;

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage write; contents need no reset since count gates validity.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_pc_mem[r_wr_ptr]    <= push_entry.pc;
         r_instr_mem[r_wr_ptr] <= push_entry.instr;
      end
   end

   generate
      if (FLAG_EN) begin : g_flag_store
         logic r_flag_mem [DEPTH];
         // Predecoded branch flag travels alongside its entry.
         always_ff @(posedge clk) begin
            if (w_do_push) r_flag_mem[r_wr_ptr] <= push_entry.is_branch;
         end
         assign w_head_flag = r_flag_mem[r_rd_ptr];
      end else begin : g_flag_none
         logic w_unused_flag;
         assign w_unused_flag = push_entry.is_branch;
         assign w_head_flag   = 1'b0;
      end
   endgenerate

   // Head entry is presented combinationally from the read pointer.
   always_comb begin
      head_entry           = '0;
      head_entry.pc        = r_pc_mem[r_rd_ptr];
      head_entry.instr     = r_instr_mem[r_rd_ptr];
      head_entry.is_branch = w_head_flag;
   end

   // Upstream credit accounting must keep a full FIFO from ever being pushed.
   always_ff @(posedge clk) begin
      if (!rst) assert (!(w_do_push && (r_count == CNT_W'(DEPTH))));
   end

endmodule
`default_nettype wire

// File: rtl/if_prefetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_prefetch_stage
//  Description : Instruction-fetch stage with decoupling prefetch queue.
//                Issues sequential reads to a 1-cycle synchronous imem,
//                buffers {pc, instr} in if_fetch_fifo and hands them to ID
//                over valid/ready. Branch_taken flushes queue and in-flight
//                read. Optional macro IF_PREDECODE_EN adds a per-entry
//                branch flag presented on out_is_branch.
//                ADDR_W must not exceed 32 and DATA_W must equal 32.
//  Revision    : 1.0  initial release
// ============================================================================
module if_prefetch_stage
   import if_pkg::*;
#(
   parameter int              ADDR_W   = 32,
   parameter int              DATA_W   = 32,
   parameter int              DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   if_prefetch_stage_if.master bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);

`ifdef IF_PREDECODE_EN
   localparam bit PREDECODE = 1'b1;
`else
   localparam bit PREDECODE = 1'b0;
`endif

   logic [ADDR_W-1:0] r_fetch_pc;
   logic [ADDR_W-1:0] r_inflight_pc;
   logic              r_inflight;
   logic [CNT_W-1:0]  w_count;
   logic [CNT_W:0]    w_credit_used;
   logic              w_issue;
   logic              w_push;
   logic              w_pop;
   logic              w_out_valid;
   fetch_entry_t      w_push_entry;
   fetch_entry_t      w_head_entry;

   // Credit counts queued plus in-flight entries; a same-cycle pop is not
   // credited, which keeps the queue from ever overflowing.
   assign w_credit_used = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
   assign w_issue       = ~rst & ~bus.freeze & ~bus.Branch_taken
                        & (w_credit_used < (CNT_W+1)'(DEPTH));
   assign w_push        = r_inflight & ~bus.Branch_taken & ~rst;
   assign w_out_valid   = (w_count != '0) & ~bus.Branch_taken;
   assign w_pop         = w_out_valid & bus.out_ready & ~bus.freeze;

   assign bus.imem_en   = w_issue;
   assign bus.imem_addr = r_fetch_pc;
   assign bus.out_valid = w_out_valid;
   assign bus.out_pc    = ADDR_W'(w_head_entry.pc);
   assign bus.out_instr = DATA_W'(w_head_entry.instr);

   // Fetch PC and in-flight tracking; redirect dominates any issue.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc    <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= RESET_PC;
      end else if (bus.Branch_taken) begin
         r_fetch_pc <= bus.BranchAddr;
         r_inflight <= 1'b0;
      end else if (w_issue) begin
         r_fetch_pc    <= r_fetch_pc + ADDR_W'(4);
         r_inflight    <= 1'b1;
         r_inflight_pc <= r_fetch_pc;
      end else begin
         r_inflight <= 1'b0;
      end
   end

   // Returning read data is tagged with the PC it was issued for.
   always_comb begin
      w_push_entry       = '0;
      w_push_entry.pc    = PC_W'(r_inflight_pc);
      w_push_entry.instr = INSTR_W'(bus.imem_rdata);
`ifdef IF_PREDECODE_EN
      w_push_entry.is_branch = is_branch_opc(INSTR_W'(bus.imem_rdata));
`endif
   end

`ifdef IF_PREDECODE_EN
   assign bus.out_is_branch = w_out_valid & w_head_entry.is_branch;
`else
   logic w_unused_head_flag;
   assign w_unused_head_flag = w_head_entry.is_branch;
   assign bus.out_is_branch  = 1'b0;
`endif

   if_fetch_fifo #(
      .DEPTH   (DEPTH),
      .FLAG_EN (PREDECODE)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .clear      (bus.Branch_taken),
      .push       (w_push),
      .pop        (w_pop),
      .push_entry (w_push_entry),
      .head_entry (w_head_entry),
      .count      (w_count)
   );

endmodule
`default_nettype wire
